// File: rtl/ucore_pkg.sv
// rtl/ucore_pkg.sv - shared ucore types and helpers
package ucore_pkg;

  typedef enum logic [1:0] {
    S_UNCFG = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fire_state_e;

  function automatic int credit_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/ucore_fire_ctrl_if.sv
// rtl/ucore_fire_ctrl_if.sv - config, input-channel and FU handshake bundle
interface ucore_fire_ctrl_if #(
  parameter int NUM_INPUTS = 3,
  parameter int DATA_WIDTH = 32
);

  logic                             cfg_valid;
  logic [NUM_INPUTS-1:0]            cfg_mask;
  logic                             cfg_ready;
  logic [NUM_INPUTS-1:0]            ch_valid;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] ch_data;
  logic [NUM_INPUTS-1:0]            ch_yumi;
  logic                             fu_valid;
  logic                             fu_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] fu_operands;
  logic                             fu_done;

  modport master (
    output cfg_valid, cfg_mask, ch_valid, ch_data, fu_ready, fu_done,
    input  cfg_ready, ch_yumi, fu_valid, fu_operands
  );

  modport slave (
    input  cfg_valid, cfg_mask, ch_valid, ch_data, fu_ready, fu_done,
    output cfg_ready, ch_yumi, fu_valid, fu_operands
  );

endinterface

// File: rtl/ucore_credit_counter.sv
// rtl/ucore_credit_counter.sv - saturating in-flight credit counter
module ucore_credit_counter
  import ucore_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          inc,
  input  logic                          dec,
  output logic [credit_width(MAX)-1:0]  count,
  output logic                          full,
  output logic                          empty,
  output logic                          underflow
);

  localparam int W = credit_width(MAX);

  assign full      = (count == W'(MAX));
  assign empty     = (count == '0);
  // A release with nothing outstanding is reported, never applied.
  assign underflow = dec & ~inc & empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + W'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/ucore_fire_ctrl.sv
// rtl/ucore_fire_ctrl.sv - dataflow firing controller for one ucore
module ucore_fire_ctrl
  import ucore_pkg::*;
#(
  parameter int NUM_INPUTS   = 3,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ucore_fire_ctrl_if.slave     bus,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] fire_count
);

  localparam int IW = credit_width(MAX_INFLIGHT);

  fire_state_e           state;
  logic [NUM_INPUTS-1:0] mask;
  logic [IW-1:0]         inflight;
  logic                  credit_full;
  logic                  credit_empty;
  logic                  credit_underflow;
  logic                  operands_ready;
  logic                  fire;
  logic                  cfg_accept;

  // Unmasked channels count as present so they never block a fire.
  assign operands_ready = &(bus.ch_valid | ~mask);
  assign fire           = (state == S_RUN) & operands_ready & bus.fu_ready & ~credit_full;

  assign bus.fu_valid  = fire;
  assign bus.ch_yumi   = {NUM_INPUTS{fire}} & mask;
  assign bus.cfg_ready = (state == S_UNCFG) | ((state == S_DRAIN) & credit_empty);
  assign cfg_accept    = bus.cfg_valid & bus.cfg_ready;
  assign busy          = ~credit_empty | (state != S_UNCFG);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    assign bus.fu_operands[i*DATA_WIDTH +: DATA_WIDTH] =
      mask[i] ? bus.ch_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  ucore_credit_counter #(
    .MAX (MAX_INFLIGHT)
  ) u_inflight (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (fire),
    .dec       (bus.fu_done),
    .count     (inflight),
    .full      (credit_full),
    .empty     (credit_empty),
    .underflow (credit_underflow)
  );

  // Accept only happens outside S_RUN, so it never coincides with a fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_UNCFG;
      mask       <= '0;
      fire_count <= '0;
      err        <= 1'b0;
    end else begin
      err <= err | credit_underflow;
      if (cfg_accept) begin
        mask       <= bus.cfg_mask;
        fire_count <= '0;
        state      <= (bus.cfg_mask != '0) ? S_RUN : S_UNCFG;
      end else begin
        if (fire) begin
          fire_count <= fire_count + CNT_WIDTH'(1);
        end
        case (state)
          S_RUN:   if (bus.cfg_valid) state <= S_DRAIN;
          S_UNCFG: state <= S_UNCFG;
          S_DRAIN: state <= S_DRAIN;
          default: state <= S_UNCFG;
        endcase
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^inflight;

endmodule

// File: tb/tb_ucore_fire_ctrl.sv
// tb/tb_ucore_fire_ctrl.sv - randomized self-checking bench for ucore_fire_ctrl
module tb_ucore_fire_ctrl;

  localparam int NI = 3;
  localparam int DW = 32;
  localparam int MI = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy;
  logic          err;
  logic [CW-1:0] fire_count;

  ucore_fire_ctrl_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) bus ();

  ucore_fire_ctrl #(
    .NUM_INPUTS   (NI),
    .DATA_WIDTH   (DW),
    .MAX_INFLIGHT (MI),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .busy       (busy),
    .err        (err),
    .fire_count (fire_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: 0 = unconfigured, 1 = running, 2 = draining
  int            m_mode;
  logic [NI-1:0] m_mask;
  int            m_inflight;
  logic          m_err;
  logic [CW-1:0] m_fc;

  function automatic logic exp_fire();
    logic ok;
    ok = (m_mode == 1) && bus.fu_ready && (m_inflight < MI);
    for (int i = 0; i < NI; i++)
      if (m_mask[i] && !bus.ch_valid[i]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [NI*DW-1:0] exp_ops();
    logic [NI*DW-1:0] r;
    for (int i = 0; i < NI; i++)
      r[i*DW +: DW] = m_mask[i] ? bus.ch_data[i*DW +: DW] : '0;
    return r;
  endfunction

  function automatic logic exp_cfg_ready();
    return (m_mode == 0) || (m_mode == 2 && m_inflight == 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_mask = '0; m_inflight = 0; m_err = 1'b0; m_fc = '0;
  endtask

  // Advance one clock, updating the reference from the inputs held this cycle.
  task automatic tick();
    logic f, acc, dn, cv;
    logic [NI-1:0] cm;
    f   = exp_fire();
    acc = bus.cfg_valid && exp_cfg_ready();
    dn  = bus.fu_done;
    cv  = bus.cfg_valid;
    cm  = bus.cfg_mask;
    @(posedge clk);
    if (f && !dn) m_inflight++;
    else if (dn && !f) begin
      if (m_inflight == 0) m_err = 1'b1;
      else m_inflight--;
    end
    if (acc) begin
      m_mask = cm; m_fc = '0; m_mode = (cm != '0) ? 1 : 0;
    end else begin
      if (f) m_fc++;
      if (m_mode == 1 && cv) m_mode = 2;
    end
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NI; i++) bus.ch_data[i*DW +: DW] = $urandom;
  endtask

  task automatic idle_inputs();
    bus.cfg_valid = 1'b0; bus.cfg_mask = '0; bus.ch_valid = '0;
    bus.fu_ready = 1'b0; bus.fu_done = 1'b0;
    rand_data();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic configure(input logic [NI-1:0] mask);
    bus.cfg_valid = 1'b1; bus.cfg_mask = mask;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    n_checks++; if (bus.fu_valid !== 1'b0) $display("FAIL reset_fu_valid got=%b exp=0", bus.fu_valid); else n_pass++;
    n_checks++; if (bus.ch_yumi !== 3'b000) $display("FAIL reset_yumi got=%b exp=000", bus.ch_yumi); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (bus.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got=%b exp=1", bus.cfg_ready); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    n_checks++; if (fire_count !== '0) $display("FAIL reset_fire_count got=%0d exp=0", fire_count); else n_pass++;
    do_reset();
  endtask

  task automatic test_basic_fire();
    do_reset();
    configure(3'b011);
    bus.ch_valid = 3'b011;
    bus.ch_data  = {32'hdeadbeef, 32'd7, 32'd5};
    bus.fu_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.fu_valid !== 1'b1) $display("FAIL basic_fu_valid got=%b exp=1", bus.fu_valid); else n_pass++;
    n_checks++; if (bus.fu_operands !== {32'd0, 32'd7, 32'd5}) $display("FAIL basic_operands got=%h exp=%h", bus.fu_operands, {32'd0, 32'd7, 32'd5}); else n_pass++;
    n_checks++; if (bus.ch_yumi !== 3'b011) $display("FAIL basic_yumi got=%b exp=011", bus.ch_yumi); else n_pass++;
    tick();
    bus.ch_valid = '0;
    @(negedge clk);
    n_checks++; if (fire_count !== 32'd1) $display("FAIL basic_fire_count got=%0d exp=1", fire_count); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else n_pass++;
    tick();
  endtask

  task automatic test_partial_tokens();
    do_reset();
    configure(3'b011);
    bus.fu_ready = 1'b1;
    bus.ch_valid = 3'b001;
    for (int c = 0; c < 10; c++) begin
      rand_data();
      @(negedge clk);
      n_checks++;
      if (bus.fu_valid !== 1'b0 || bus.ch_yumi !== 3'b000)
        $display("FAIL partial_hold cyc=%0d got fu_valid=%b yumi=%b exp 0/000", c, bus.fu_valid, bus.ch_yumi);
      else n_pass++;
      tick();
    end
    bus.ch_valid = 3'b011;
    @(negedge clk);
    n_checks++; if (bus.fu_valid !== 1'b1) $display("FAIL partial_release_fire got=%b exp=1", bus.fu_valid); else n_pass++;
    n_checks++; if (bus.ch_yumi !== 3'b011) $display("FAIL partial_release_yumi got=%b exp=011", bus.ch_yumi); else n_pass++;
    tick();
  endtask

  task automatic test_credits();
    int fires;
    do_reset();
    configure(3'b111);
    bus.ch_valid = 3'b111;
    bus.fu_ready = 1'b1;
    fires = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.fu_valid === 1'b1) fires++;
      tick();
    end
    n_checks++; if (fires !== MI) $display("FAIL credit_limit got=%0d exp=%0d", fires, MI); else n_pass++;
    bus.fu_done = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.fu_valid !== 1'b0) $display("FAIL credit_full_stall got=%b exp=0", bus.fu_valid); else n_pass++;
    tick();
    bus.fu_done = 1'b0;
    fires = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.fu_valid === 1'b1) fires++;
      tick();
    end
    n_checks++; if (fires !== 1) $display("FAIL credit_one_more got=%0d exp=1", fires); else n_pass++;
    @(negedge clk);
    n_checks++; if (fire_count !== m_fc) $display("FAIL credit_fire_count got=%0d exp=%0d", fire_count, m_fc); else n_pass++;
    tick();
  endtask

  task automatic test_fire_and_done();
    int fires;
    do_reset();
    configure(3'b001);
    bus.ch_valid = 3'b001;
    bus.fu_ready = 1'b1;
    tick();
    tick();
    bus.fu_done = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.fu_valid !== 1'b1) $display("FAIL simul_fire got=%b exp=1", bus.fu_valid); else n_pass++;
    tick();
    bus.fu_done = 1'b0;
    fires = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.fu_valid === 1'b1) fires++;
      tick();
    end
    n_checks++; if (fires !== 2) $display("FAIL simul_inflight_kept got=%0d exp=2", fires); else n_pass++;
    bus.fu_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== 1'b0) $display("FAIL simul_no_err got=%b exp=0", err); else n_pass++;
    bus.fu_done = 1'b1;
    repeat (MI + 1) tick();
    bus.fu_done = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL underflow_err got=%b exp=1", err); else n_pass++;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL underflow_sticky got=%b exp=1", err); else n_pass++;
    tick();
  endtask

  task automatic test_reconfig();
    do_reset();
    configure(3'b011);
    bus.ch_valid = 3'b011;
    bus.fu_ready = 1'b1;
    tick();
    tick();
    bus.ch_valid  = '0;
    bus.cfg_valid = 1'b1;
    bus.cfg_mask  = 3'b101;
    @(negedge clk);
    n_checks++; if (bus.cfg_ready !== 1'b0) $display("FAIL reconfig_run_ready got=%b exp=0", bus.cfg_ready); else n_pass++;
    tick();
    bus.ch_valid = 3'b111;
    bus.fu_done  = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.fu_valid !== 1'b0) $display("FAIL reconfig_drain_nofire got=%b exp=0", bus.fu_valid); else n_pass++;
    n_checks++; if (bus.cfg_ready !== 1'b0) $display("FAIL reconfig_drain_ready2 got=%b exp=0", bus.cfg_ready); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.cfg_ready !== 1'b0) $display("FAIL reconfig_drain_ready1 got=%b exp=0", bus.cfg_ready); else n_pass++;
    tick();
    bus.fu_done = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cfg_ready !== 1'b1) $display("FAIL reconfig_drained_ready got=%b exp=1", bus.cfg_ready); else n_pass++;
    tick();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (fire_count !== '0) $display("FAIL reconfig_count_clear got=%0d exp=0", fire_count); else n_pass++;
    n_checks++; if (bus.ch_yumi !== 3'b101) $display("FAIL reconfig_new_mask got=%b exp=101", bus.ch_yumi); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    configure(3'b111);
    bus.ch_valid = 3'b111;
    bus.fu_ready = 1'b1;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.fu_valid !== 1'b0) $display("FAIL midrst_fu_valid got=%b exp=0", bus.fu_valid); else n_pass++;
    n_checks++; if (bus.ch_yumi !== 3'b000) $display("FAIL midrst_yumi got=%b exp=000", bus.ch_yumi); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (bus.cfg_ready !== 1'b1) $display("FAIL midrst_cfg_ready got=%b exp=1", bus.cfg_ready); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.ch_valid = '0;
    bus.fu_done  = 1'b1;
    tick();
    bus.fu_done = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL midrst_stale_done_err got=%b exp=1", err); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic acc;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!bus.cfg_valid && $urandom_range(0, 15) == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_mask  = NI'($urandom_range(0, 7));
      end
      bus.ch_valid = NI'($urandom_range(0, 7));
      rand_data();
      bus.fu_ready = ($urandom_range(0, 3) != 0);
      bus.fu_done  = (m_inflight > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      @(negedge clk);
      n_checks++; if (bus.fu_valid !== exp_fire()) $display("FAIL rand_fu_valid cyc=%0d got=%b exp=%b", c, bus.fu_valid, exp_fire()); else n_pass++;
      n_checks++; if (bus.ch_yumi !== ({NI{exp_fire()}} & m_mask)) $display("FAIL rand_yumi cyc=%0d got=%b exp=%b", c, bus.ch_yumi, {NI{exp_fire()}} & m_mask); else n_pass++;
      n_checks++; if (bus.fu_operands !== exp_ops()) $display("FAIL rand_operands cyc=%0d got=%h exp=%h", c, bus.fu_operands, exp_ops()); else n_pass++;
      n_checks++; if (bus.cfg_ready !== exp_cfg_ready()) $display("FAIL rand_cfg_ready cyc=%0d got=%b exp=%b", c, bus.cfg_ready, exp_cfg_ready()); else n_pass++;
      n_checks++; if (busy !== (m_inflight != 0 || m_mode != 0)) $display("FAIL rand_busy cyc=%0d got=%b exp=%b", c, busy, (m_inflight != 0 || m_mode != 0)); else n_pass++;
      n_checks++; if (err !== m_err) $display("FAIL rand_err cyc=%0d got=%b exp=%b", c, err, m_err); else n_pass++;
      n_checks++; if (fire_count !== m_fc) $display("FAIL rand_fire_count cyc=%0d got=%0d exp=%0d", c, fire_count, m_fc); else n_pass++;
      acc = bus.cfg_valid && exp_cfg_ready();
      tick();
      if (acc) bus.cfg_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_fire();
    test_partial_tokens();
    test_credits();
    test_fire_and_done();
    test_reconfig();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
